// File: rtl/fsic_io_serdes_link_ctrl_pkg.sv
// Shared encodings for the IO SERDES link bring-up sequencer.
// States, enable register values and bit positions.
package fsic_io_serdes_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_RX     = 3'd1,
    ST_DLY       = 3'd2,
    ST_WR_TX     = 3'd3,
    ST_WAIT_LINK = 3'd4,
    ST_VERIFY    = 3'd5,
    ST_UP        = 3'd6,
    ST_ERR       = 3'd7
  } link_st_e;

  localparam logic [31:0] SERDES_REG_RXEN = 32'h1;
  localparam logic [31:0] SERDES_REG_TXRX = 32'h3;

  localparam int RXEN_BIT = 0;
  localparam int TXEN_BIT = 1;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/fsic_io_serdes_link_ctrl_axil.sv
// Single-shot AXI-Lite master: one write or one read per request pulse.
// Ports: wr_req/rd_req in, wr_done/rd_done/rd_data out, AW/W/AR/R channel.
module fsic_axil_single_master #(
  parameter int                    pADDR_WIDTH = 15,
  parameter int                    pDATA_WIDTH = 32,
  parameter logic [pADDR_WIDTH-1:0] pADDR      = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_req,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_req,
  output logic                   wr_done,
  output logic                   rd_done,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic                   m_awvalid,
  output logic [pADDR_WIDTH-1:0] m_awaddr,
  input  logic                   m_awready,
  output logic                   m_wvalid,
  output logic [pDATA_WIDTH-1:0] m_wdata,
  output logic [3:0]             m_wstrb,
  input  logic                   m_wready,
  output logic                   m_arvalid,
  output logic [pADDR_WIDTH-1:0] m_araddr,
  input  logic                   m_arready,
  input  logic                   m_rvalid,
  input  logic [pDATA_WIDTH-1:0] m_rdata,
  output logic                   cc_is_enable
);

  logic                   aw_q;
  logic                   ar_q;
  logic                   r_wait_q;
  logic [pDATA_WIDTH-1:0] wdata_q;
  logic                   ar_hs;

  // AW and W share one valid; only a joint ready completes.
  assign wr_done = aw_q & m_awready & m_wready;
  assign ar_hs   = ar_q & m_arready;
  // R may land in the AR acceptance cycle or any later one.
  assign rd_done = (ar_hs | r_wait_q) & m_rvalid;
  assign rd_data = m_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_q     <= 1'b0;
      ar_q     <= 1'b0;
      r_wait_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      if (wr_req) begin
        aw_q    <= 1'b1;
        wdata_q <= wr_data;
      end else if (wr_done) begin
        aw_q <= 1'b0;
      end
      if (rd_req) begin
        ar_q <= 1'b1;
      end else if (ar_hs) begin
        ar_q <= 1'b0;
      end
      if (rd_done) begin
        r_wait_q <= 1'b0;
      end else if (ar_hs) begin
        r_wait_q <= 1'b1;
      end
    end
  end

  assign m_awvalid    = aw_q;
  assign m_wvalid     = aw_q;
  assign m_awaddr     = aw_q ? pADDR : '0;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = aw_q ? 4'hF : 4'h0;
  assign m_arvalid    = ar_q;
  assign m_araddr     = ar_q ? pADDR : '0;
  assign cc_is_enable = aw_q | ar_q;

endmodule

// File: rtl/fsic_io_serdes_link_ctrl.sv
// IO SERDES link bring-up: rxen, delay, txen, wait for link, verify.
// Ports: ctl_start/link_rx_seen in, AXI-Lite master, sts_* status out.
module fsic_io_serdes_link_ctrl
  import fsic_io_serdes_link_ctrl_pkg::*;
#(
  parameter int                     pADDR_WIDTH    = 15,
  parameter int                     pDATA_WIDTH    = 32,
  parameter logic [pADDR_WIDTH-1:0] pSERDES_OFFSET = '0,
  parameter int                     pRX_TX_DLY     = 16,
  parameter int                     pLINK_TIMEOUT  = 4096,
  parameter int                     pMAX_RETRY     = 3
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   ctl_start,
  input  logic                   link_rx_seen,
  output logic                   cc_is_enable,
  output logic                   m_awvalid,
  output logic [pADDR_WIDTH-1:0] m_awaddr,
  input  logic                   m_awready,
  output logic                   m_wvalid,
  output logic [pDATA_WIDTH-1:0] m_wdata,
  output logic [3:0]             m_wstrb,
  input  logic                   m_wready,
  output logic                   m_arvalid,
  output logic [pADDR_WIDTH-1:0] m_araddr,
  input  logic                   m_arready,
  input  logic                   m_rvalid,
  input  logic [pDATA_WIDTH-1:0] m_rdata,
  output logic                   m_rready,
  output logic [2:0]             sts_state,
  output logic                   sts_link_up,
  output logic                   sts_err,
  output logic [3:0]             sts_retry_cnt
);

  localparam int CNT_W = cnt_width(pRX_TX_DLY, pLINK_TIMEOUT);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(pRX_TX_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(pLINK_TIMEOUT - 1);

  link_st_e               state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_sat;
  logic [3:0]             retry, retry_nxt;
  logic                   wr_req, rd_req, wr_done, rd_done;
  logic [pDATA_WIDTH-1:0] wr_data, rd_data;
  logic                   unused_rdata;

  fsic_axil_single_master #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .pADDR       (pSERDES_OFFSET)
  ) u_axil (
    .clk          (axi_clk),
    .rst_n        (axi_reset_n),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .wr_done      (wr_done),
    .rd_done      (rd_done),
    .rd_data      (rd_data),
    .m_awvalid    (m_awvalid),
    .m_awaddr     (m_awaddr),
    .m_awready    (m_awready),
    .m_wvalid     (m_wvalid),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_wready     (m_wready),
    .m_arvalid    (m_arvalid),
    .m_araddr     (m_araddr),
    .m_arready    (m_arready),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .cc_is_enable (cc_is_enable)
  );

  // Only the two enable bits matter on read-back.
  assign unused_rdata = ^rd_data;

  assign cnt_sat = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      retry <= retry_nxt;
    end
  end

  // Requests fire on the transition so valids rise on state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    wr_data   = pDATA_WIDTH'(SERDES_REG_TXRX);
    unique case (state)
      ST_IDLE, ST_ERR: begin
        if (ctl_start) begin
          state_nxt = ST_WR_RX;
          retry_nxt = '0;
          wr_req    = 1'b1;
          wr_data   = pDATA_WIDTH'(SERDES_REG_RXEN);
        end
      end
      ST_WR_RX: begin
        if (wr_done) begin
          state_nxt = ST_DLY;
          cnt_nxt   = '0;
        end
      end
      ST_DLY: begin
        if (cnt == DLY_LAST) begin
          state_nxt = ST_WR_TX;
          wr_req    = 1'b1;
        end else begin
          cnt_nxt = cnt_sat;
        end
      end
      ST_WR_TX: begin
        if (wr_done) begin
          state_nxt = ST_WAIT_LINK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LINK: begin
        if (link_rx_seen) begin
          state_nxt = ST_VERIFY;
          rd_req    = 1'b1;
        end else if (cnt == TO_LAST) begin
          if (retry < 4'(pMAX_RETRY)) begin
            state_nxt = ST_WR_TX;
            retry_nxt = retry + 4'd1;
            wr_req    = 1'b1;
          end else begin
            state_nxt = ST_ERR;
          end
        end else begin
          cnt_nxt = cnt_sat;
        end
      end
      ST_VERIFY: begin
        if (rd_done) begin
          if (rd_data[TXEN_BIT] && rd_data[RXEN_BIT]) begin
            state_nxt = ST_UP;
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_UP: begin
        state_nxt = ST_UP;
      end
    endcase
  end

  assign m_rready      = (state == ST_VERIFY);
  assign sts_state     = state;
  assign sts_link_up   = (state == ST_UP);
  assign sts_err       = (state == ST_ERR);
  assign sts_retry_cnt = retry;

endmodule

// File: tb/tb_fsic_io_serdes_link_ctrl.sv
// Bench for fsic_io_serdes_link_ctrl: AXI-Lite slave model plus
// directed and randomized bring-up scenarios with a transaction log.
module tb_fsic_io_serdes_link_ctrl;

  localparam int DLY  = 16;
  localparam int TO   = 64;
  localparam int MAXR = 3;

  logic        clk = 0, rst_n = 0, start = 0, link = 0;
  logic        cc, m_awvalid, m_wvalid, m_arvalid, m_rready;
  logic [14:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb, sts_retry_cnt;
  logic        m_awready, m_wready, m_arready, m_rvalid;
  logic [2:0]  sts_state;
  logic        sts_link_up, sts_err;

  fsic_io_serdes_link_ctrl #(.pLINK_TIMEOUT(TO)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .ctl_start(start),
    .link_rx_seen(link), .cc_is_enable(cc),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wready(m_wready), .m_arvalid(m_arvalid), .m_araddr(m_araddr),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rready(m_rready), .sts_state(sts_state), .sts_link_up(sts_link_up),
    .sts_err(sts_err), .sts_retry_cnt(sts_retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [14:0] addr;
    logic [3:0]  strb;
    int          len;
  } wr_t;

  wr_t         wq[$];
  int          cyc = 0, aw_run = 0, n_ar = 0;
  logic [14:0] ar_addr_last;
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int          aw_age = 0, ar_age = 0, r_age = 0;
  bit          r_pend = 0;
  logic [31:0] rdata_val = 32'h3;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction log, sampled at the active edge.
  always @(posedge clk) begin
    if (m_awvalid) aw_run++;
    else aw_run = 0;
    if (m_awvalid && m_awready && m_wready)
      wq.push_back('{cyc, m_wdata, m_awaddr, m_wstrb, aw_run});
    if (m_arvalid && m_arready) begin
      n_ar++;
      ar_addr_last = m_araddr;
      r_pend = !m_rvalid;
      r_age = 0;
    end
    cyc++;
  end

  // Slave responses and per-cycle protocol rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_awready = 0; m_wready = 0; m_arready = 0; m_rvalid = 0;
      aw_age = 0; ar_age = 0; r_age = 0; r_pend = 0;
      m_rdata = 32'hdead_beef;
    end else begin
      aw_age = m_awvalid ? aw_age + 1 : 0;
      m_awready = m_awvalid && (aw_age > aw_dly);
      m_wready  = m_awvalid && (aw_age > w_dly);
      ar_age = m_arvalid ? ar_age + 1 : 0;
      m_arready = m_arvalid && (ar_age > ar_dly);
      m_rvalid = 0;
      if (m_arready && r_dly == 0) m_rvalid = 1;
      else if (r_pend) begin
        r_age++;
        if (r_age >= r_dly) begin
          m_rvalid = 1;
          r_pend = 0;
        end
      end
      m_rdata = m_rvalid ? rdata_val : 32'hdead_beef;
      check("cc_en", cc, m_awvalid | m_wvalid | m_arvalid);
      check("aw_w_pair", m_awvalid, m_wvalid);
      check("rready_verify", m_rready, sts_state == 3'd5);
      if (m_awvalid) begin
        check("awaddr", m_awaddr, 0);
        check("wstrb", m_wstrb, 4'hF);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; link = 0;
    tick(2);
    wq.delete();
    n_ar = 0;
    rst_n = 1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s,
                            input int budget);
    int i = 0;
    while (sts_state !== s && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, sts_state, s);
  endtask

  task automatic wait_final(input string tag, input int budget);
    int i = 0;
    while (sts_state !== 3'd6 && sts_state !== 3'd7 && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, "_done"}, (sts_state === 3'd6) || (sts_state === 3'd7), 1);
  endtask

  // Expected log: rxen write then n_tx txen writes, all at offset 0.
  task automatic check_writes(input string tag, input int n_tx);
    int len;
    len = ((aw_dly > w_dly) ? aw_dly : w_dly) + 1;
    check({tag, "_nwr"}, wq.size(), 1 + n_tx);
    for (int i = 0; i < wq.size() && i <= n_tx; i++) begin
      check({tag, "_wdata"}, wq[i].data, (i == 0) ? 32'h1 : 32'h3);
      check({tag, "_waddr"}, wq[i].addr, 0);
      check({tag, "_wlen"}, wq[i].len, len);
    end
    if (wq.size() >= 2)
      check({tag, "_gap"}, wq[1].cyc - wq[0].cyc, DLY + len);
  endtask

  initial begin
    int H, link_at, i;
    bit exp_up;

    // Reset values.
    tick(1);
    check("rst_ctl", {m_awvalid, m_wvalid, m_arvalid, m_rready, cc,
                      m_wstrb, sts_state, sts_link_up, sts_err,
                      sts_retry_cnt}, 0);
    check("rst_data", {m_awaddr, m_araddr, m_wdata}, 0);
    do_reset();

    // 1: immediate slave, link at 50 cycles, rdata 3.
    rdata_val = 32'h3;
    pulse_start();
    check("t1_wr_rx", sts_state, 3'd1);
    tick(49);
    link = 1;
    wait_state("t1_up", 3'd6, 200);
    check("t1_link_up", sts_link_up, 1);
    check("t1_err", sts_err, 0);
    check("t1_retry", sts_retry_cnt, 0);
    check_writes("t1", 1);
    check("t1_nar", n_ar, 1);
    check("t1_araddr", ar_addr_last, 0);
    pulse_start();
    tick(2);
    check("t1_up_hold", sts_state, 3'd6);
    check("t1_nwr_hold", wq.size(), 2);

    // 2: awready 3 cycles ahead of wready; R in the AR cycle.
    do_reset();
    aw_dly = 0; w_dly = 3; ar_dly = 1; r_dly = 0;
    link = 1;
    pulse_start();
    wait_state("t2_up", 3'd6, 200);
    check_writes("t2", 1);
    check("t2_nar", n_ar, 1);

    // 3: link never seen -> three retries then ERR.
    do_reset();
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
    pulse_start();
    wait_state("t3_err", 3'd7, 800);
    check("t3_sts_err", sts_err, 1);
    check("t3_retry", sts_retry_cnt, MAXR);
    check_writes("t3", 1 + MAXR);
    for (int k = 2; k < wq.size(); k++)
      check("t3_retry_gap", wq[k].cyc - wq[k-1].cyc, TO + 1);
    check("t3_nar", n_ar, 0);

    // 4: restart from ERR; link coincides with the 2nd timeout.
    wq.delete();
    pulse_start();
    check("t4_wr_rx", sts_state, 3'd1);
    check("t4_retry_clr", sts_retry_cnt, 0);
    i = 0;
    while (wq.size() < 3 && i < 400) begin
      tick(1);
      i++;
    end
    check("t4_nwr", wq.size(), 3);
    if (wq.size() >= 3) begin
      H = wq[2].cyc;
      i = 0;
      while (cyc < H + TO && i < 400) begin
        tick(1);
        i++;
      end
      link = 1;
      tick(1);
      check("t4_verify", sts_state, 3'd5);
      check("t4_retry", sts_retry_cnt, 1);
      wait_state("t4_up", 3'd6, 100);
      check("t4_nwr_final", wq.size(), 3);
    end

    // 5: read-back 1 with rvalid 2 cycles after AR -> ERR, restart.
    do_reset();
    rdata_val = 32'h1; r_dly = 2;
    link = 1;
    pulse_start();
    wait_state("t5_err", 3'd7, 200);
    check("t5_sts_err", sts_err, 1);
    check("t5_nar", n_ar, 1);
    wq.delete();
    aw_dly = 6; w_dly = 6;
    link = 0;
    pulse_start();
    check("t5_restart", sts_state, 3'd1);
    check("t5_retry", sts_retry_cnt, 0);

    // 6: start ignored in DLY; async reset mid-WR_TX.
    wait_state("t6_dly", 3'd2, 50);
    pulse_start();
    check("t6_dly_hold", sts_state, 3'd2);
    check("t6_nwr", wq.size(), 1);
    wait_state("t6_wr_tx", 3'd3, 50);
    tick(2);
    check("t6_valid_hi", m_awvalid, 1);
    #2 rst_n = 0;
    #1;
    check("t6_arst_ctl", {m_awvalid, m_wvalid, m_arvalid, m_rready, cc,
                          m_wstrb, sts_state, sts_link_up, sts_err,
                          sts_retry_cnt}, 0);
    check("t6_arst_data", {m_awaddr, m_araddr, m_wdata}, 0);
    tick(1);
    rst_n = 1;
    tick(3);
    check("t6_idle", sts_state, 3'd0);
    check("t6_no_valid", m_awvalid, 0);

    // Randomized bring-ups against the outcome model.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      aw_dly = $urandom_range(0, 4);
      w_dly  = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      rdata_val = $urandom;
      if ($urandom_range(0, 1) == 1) rdata_val[1:0] = 2'b11;
      exp_up = (rdata_val[1:0] == 2'b11);
      link_at = $urandom_range(0, 40);
      pulse_start();
      tick(link_at);
      link = 1;
      wait_final("rnd", 300);
      check("rnd_state", sts_state, exp_up ? 3'd6 : 3'd7);
      check("rnd_link_up", sts_link_up, exp_up);
      check("rnd_err", sts_err, !exp_up);
      check("rnd_retry", sts_retry_cnt, 0);
      check("rnd_nar", n_ar, 1);
      check_writes("rnd", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
